// File: rtl/iceboard_regfile_v2.sv
// iceboard_regfile_v2: Avalon-MM register bank for the iCEboard motor controller.
// Holds per-motor PID/limit configuration and per-motor status, with a command
// FIFO carrying control-mode/setpoint update requests to the coms engine.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   address/write/writedata/
//   read/readdata/waitrequest   Avalon-MM slave ([15:8] register, [7:0] motor)
//   st_wr_*                     status write port from coms
//   cfg_rd_motor/sel/data       1-cycle registered configuration read port
//   cmd_valid/ready/type/motor  command FIFO head with valid/ready handshake
//   status_update_hz            status frequency register
module iceboard_regfile_v2 #(
  parameter int unsigned NUM_MOTORS             = 6,
  parameter int unsigned CMD_FIFO_DEPTH         = 8,
  parameter logic [31:0] ID_VALUE               = 32'hB15B0002,
  parameter int unsigned DEFAULT_PWM_LIMIT      = 127,
  parameter int unsigned DEFAULT_INTEGRAL_LIMIT = 50,
  parameter int unsigned DEFAULT_STATUS_HZ      = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        st_wr_valid,
  input  logic [7:0]  st_wr_motor,
  input  logic [2:0]  st_wr_sel,
  input  logic [31:0] st_wr_data,
  input  logic [7:0]  cfg_rd_motor,
  input  logic [2:0]  cfg_rd_sel,
  output logic [31:0] cfg_rd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_type,
  output logic [7:0]  cmd_motor,
  output logic [31:0] status_update_hz
);

  localparam int unsigned MW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int unsigned AW = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [31:0] BAD_VALUE = 32'hDEADBEEF;

  // Configuration word order: Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband, control_mode, setpoint
  logic [31:0] cfg_mem [NUM_MOTORS][8];
  // Status word order: enc0pos, enc1pos, enc0vel, enc1vel, cur1, cur2, cur3, error_code
  logic [31:0] st_mem  [NUM_MOTORS][8];

  logic [8:0]    fifo_mem [CMD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic        rd_phase;
  logic [31:0] bad_access;

  logic [7:0]    addr, motor;
  logic          motor_ok, st_ok, cfg_rd_ok;
  logic [MW-1:0] midx, sidx, cidx;
  logic          cfg_hit, st_hit, cmd_addr;
  logic [2:0]    cfg_sel, st_sel;
  logic          fifo_full, rd_capture, wr_commit, push, pop;
  logic          rd_bad, bad_evt;
  logic [31:0]   rd_mux;

  assign addr      = address[15:8];
  assign motor     = address[7:0];
  assign motor_ok  = 32'(motor) < NUM_MOTORS;
  assign st_ok     = 32'(st_wr_motor) < NUM_MOTORS;
  assign cfg_rd_ok = 32'(cfg_rd_motor) < NUM_MOTORS;
  assign midx      = MW'(motor);
  assign sidx      = MW'(st_wr_motor);
  assign cidx      = MW'(cfg_rd_motor);
  assign cmd_addr  = (addr == 8'h0E) || (addr == 8'h0F);

  assign fifo_full   = (level == LW'(CMD_FIFO_DEPTH));
  assign rd_capture  = read && !rd_phase;
  assign waitrequest = rd_capture || (write && cmd_addr && (writedata != 32'd0) && fifo_full);
  // A simultaneous read wins; the write is dropped.
  assign wr_commit   = write && !read && !waitrequest;
  assign push        = wr_commit && cmd_addr && (writedata != 32'd0);
  assign pop         = cmd_valid && cmd_ready;

  assign cmd_valid = (level != '0);
  assign cmd_type  = fifo_mem[rd_ptr][8];
  assign cmd_motor = fifo_mem[rd_ptr][7:0];

  // Map the register select onto the per-motor config/status word index
  always_comb begin
    cfg_hit = 1'b0;
    cfg_sel = 3'd0;
    st_hit  = 1'b0;
    st_sel  = 3'd0;
    case (addr)
      8'h01: begin cfg_hit = 1'b1; cfg_sel = 3'd0; end
      8'h02: begin cfg_hit = 1'b1; cfg_sel = 3'd1; end
      8'h03: begin cfg_hit = 1'b1; cfg_sel = 3'd2; end
      8'h08: begin cfg_hit = 1'b1; cfg_sel = 3'd3; end
      8'h09: begin cfg_hit = 1'b1; cfg_sel = 3'd4; end
      8'h0A: begin cfg_hit = 1'b1; cfg_sel = 3'd5; end
      8'h0B: begin cfg_hit = 1'b1; cfg_sel = 3'd6; end
      8'h0C: begin cfg_hit = 1'b1; cfg_sel = 3'd7; end
      8'h04: begin st_hit = 1'b1; st_sel = 3'd0; end
      8'h05: begin st_hit = 1'b1; st_sel = 3'd1; end
      8'h06: begin st_hit = 1'b1; st_sel = 3'd2; end
      8'h07: begin st_hit = 1'b1; st_sel = 3'd3; end
      8'h12: begin st_hit = 1'b1; st_sel = 3'd4; end
      8'h13: begin st_hit = 1'b1; st_sel = 3'd5; end
      8'h14: begin st_hit = 1'b1; st_sel = 3'd6; end
      8'h0D: begin st_hit = 1'b1; st_sel = 3'd7; end
      default: ;
    endcase
  end

  // Avalon read data selection; per-motor hits with a bad index flag an error
  always_comb begin
    rd_mux = BAD_VALUE;
    rd_bad = 1'b0;
    case (addr)
      8'h00: rd_mux = ID_VALUE;
      8'h10: rd_mux = 32'(level);
      8'h11: rd_mux = status_update_hz;
      8'h15: rd_mux = bad_access;
      default: begin
        if (cfg_hit || st_hit) begin
          if (!motor_ok)    rd_bad = 1'b1;
          else if (cfg_hit) rd_mux = cfg_mem[midx][cfg_sel];
          else              rd_mux = st_mem[midx][st_sel];
        end
      end
    endcase
  end

  // Command entries are not range-checked; only config/status accesses are
  assign bad_evt = (rd_capture && rd_bad) || (wr_commit && (cfg_hit || st_hit) && !motor_ok);

  // Avalon-side state, configuration bank and FIFO control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_phase         <= 1'b0;
      readdata         <= 32'd0;
      cfg_rd_data      <= 32'd0;
      bad_access       <= 32'd0;
      status_update_hz <= DEFAULT_STATUS_HZ;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
        cfg_mem[MW'(m)][0] <= 32'd1;
        cfg_mem[MW'(m)][1] <= 32'd0;
        cfg_mem[MW'(m)][2] <= 32'd0;
        cfg_mem[MW'(m)][3] <= DEFAULT_PWM_LIMIT;
        cfg_mem[MW'(m)][4] <= DEFAULT_INTEGRAL_LIMIT;
        cfg_mem[MW'(m)][5] <= 32'd0;
        cfg_mem[MW'(m)][6] <= 32'd0;
        cfg_mem[MW'(m)][7] <= 32'd0;
      end
    end else begin
      rd_phase <= rd_capture;
      if (rd_capture) readdata <= rd_mux;

      cfg_rd_data <= cfg_rd_ok ? cfg_mem[cidx][cfg_rd_sel] : BAD_VALUE;

      if (wr_commit && cfg_hit && motor_ok)
        cfg_mem[midx][cfg_sel] <= (cfg_sel == 3'd6) ? {24'd0, writedata[7:0]} : writedata;

      if (wr_commit && (addr == 8'h11)) status_update_hz <= writedata;

      // Any write to the counter clears it; otherwise count saturating
      if (wr_commit && (addr == 8'h15))           bad_access <= 32'd0;
      else if (bad_evt && (bad_access != '1))     bad_access <= bad_access + 32'd1;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // Command FIFO storage: {type, motor}
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {addr[0], motor};
  end

  // Status bank, written only by the coms engine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned m = 0; m < NUM_MOTORS; m++)
        for (int unsigned s = 0; s < 8; s++)
          st_mem[MW'(m)][3'(s)] <= 32'd0;
    end else if (st_wr_valid && st_ok) begin
      st_mem[sidx][st_wr_sel] <= st_wr_data;
    end
  end

endmodule

// File: tb/tb_iceboard_regfile_v2.sv
module tb_iceboard_regfile_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        st_wr_valid;
  logic [7:0]  st_wr_motor;
  logic [2:0]  st_wr_sel;
  logic [31:0] st_wr_data;
  logic [7:0]  cfg_rd_motor;
  logic [2:0]  cfg_rd_sel;
  logic [31:0] cfg_rd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [7:0]  cmd_motor;
  logic [31:0] status_update_hz;

  int total = 0;
  int bad   = 0;

  iceboard_regfile_v2 dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .waitrequest(waitrequest),
    .st_wr_valid(st_wr_valid), .st_wr_motor(st_wr_motor), .st_wr_sel(st_wr_sel),
    .st_wr_data(st_wr_data), .cfg_rd_motor(cfg_rd_motor), .cfg_rd_sel(cfg_rd_sel),
    .cfg_rd_data(cfg_rd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_motor(cmd_motor), .status_update_hz(status_update_hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit wr, input logic [15:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle Avalon read; returns data and waitrequest in both cycles
  task automatic av_read(input logic [15:0] a, output logic [31:0] d,
                         output logic w1, output logic w2);
    address = a;
    read    = 1'b1;
    #1;
    w1 = waitrequest;
    tick();
    w2 = waitrequest;
    d  = readdata;
    tick();
    read = 1'b0;
  endtask

  task automatic av_write(input logic [15:0] a, input logic [31:0] d, output logic w0);
    int n;
    address   = a;
    writedata = d;
    write     = 1'b1;
    #1;
    w0 = waitrequest;
    n  = 0;
    while (waitrequest && n < 20) begin
      tick();
      n++;
    end
    check("write_timeout", 32'(waitrequest), 32'd0);
    tick();
    write = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [15:0] a, input logic [31:0] e);
    logic [31:0] d;
    logic w1, w2;
    av_read(a, d, w1, w2);
    check(name, d, e);
  endtask

  task automatic st_write(input logic [7:0] m, input logic [2:0] s, input logic [31:0] d);
    st_wr_valid = 1'b1;
    st_wr_motor = m;
    st_wr_sel   = s;
    st_wr_data  = d;
    tick();
    st_wr_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic w0, w1, w2;

    reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
    st_wr_valid = 1'b0; st_wr_motor = '0; st_wr_sel = '0; st_wr_data = '0;
    cfg_rd_motor = '0; cfg_rd_sel = '0; cmd_ready = 1'b0;

    // Reset state
    #12;
    check("rst readdata", readdata, 32'd0);
    check("rst cfg_rd_data", cfg_rd_data, 32'd0);
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst waitrequest", 32'(waitrequest), 32'd0);
    check("rst status_hz", status_update_hz, 32'd100);
    reset = 1'b0;
    tick();

    // Directed register vectors
    vecs.push_back(mk(0, 16'h0000, 0, 32'hB15B0002));
    vecs.push_back(mk(0, 16'h0100, 0, 32'd1));
    vecs.push_back(mk(0, 16'h0803, 0, 32'd127));
    vecs.push_back(mk(0, 16'h0905, 0, 32'd50));
    vecs.push_back(mk(0, 16'h1100, 0, 32'd100));
    vecs.push_back(mk(0, 16'h1000, 0, 32'd0));
    vecs.push_back(mk(0, 16'h1500, 0, 32'd0));
    vecs.push_back(mk(1, 16'h0C02, 32'hFFFFFE0C, 0));
    vecs.push_back(mk(0, 16'h0C02, 0, 32'hFFFFFE0C));
    vecs.push_back(mk(1, 16'h0B01, 32'h00001234, 0));
    vecs.push_back(mk(0, 16'h0B01, 0, 32'h00000034));
    vecs.push_back(mk(0, 16'h3000, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 16'h3000, 32'd5, 0));
    vecs.push_back(mk(0, 16'h0E00, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 16'h1100, 32'd250, 0));
    vecs.push_back(mk(0, 16'h1100, 0, 32'd250));
    vecs.push_back(mk(0, 16'h0400, 0, 32'd0));
    vecs.push_back(mk(0, 16'h0106, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 16'h0206, 32'd9, 0));
    vecs.push_back(mk(0, 16'h0205, 0, 32'd0));
    vecs.push_back(mk(0, 16'h1500, 0, 32'd2));
    vecs.push_back(mk(1, 16'h1500, 32'd0, 0));
    vecs.push_back(mk(0, 16'h1500, 0, 32'd0));
    vecs.push_back(mk(1, 16'h0E00, 32'd0, 0));
    vecs.push_back(mk(0, 16'h1000, 0, 32'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        av_write(vecs[i].addr, vecs[i].data, w0);
        check($sformatf("vec%0d write_nowait", i), 32'(w0), 32'd0);
      end else begin
        av_read(vecs[i].addr, d, w1, w2);
        check($sformatf("vec%0d rdata", i), d, vecs[i].exp);
        check($sformatf("vec%0d wait_seq", i), 32'({w1, w2}), 32'h2);
      end
    end
    check("status_hz port", status_update_hz, 32'd250);

    // Config read port: setpoint of motor 2
    cfg_rd_motor = 8'd2; cfg_rd_sel = 3'd7;
    tick();
    check("cfg_rd setpoint", cfg_rd_data, 32'hFFFFFE0C);

    // Config write vs cfg_rd of the same register: old value first
    cfg_rd_sel = 3'd0;
    address = 16'h0102; writedata = 32'd55; write = 1'b1;
    tick();
    write = 1'b0;
    check("cfg_coll old", cfg_rd_data, 32'd1);
    tick();
    check("cfg_coll new", cfg_rd_data, 32'd55);

    // Fill the FIFO
    for (int m = 0; m < 8; m++) begin
      av_write({8'h0F, 8'(m)}, 32'd1, w0);
      check($sformatf("fill%0d nowait", m), 32'(w0), 32'd0);
    end
    read_expect("fifo level full", 16'h1000, 32'd8);
    check("head0 type", 32'(cmd_type), 32'd1);
    check("head0 motor", 32'(cmd_motor), 32'd0);

    // Ninth push stalls until a pop frees an entry
    address = 16'h0E01; writedata = 32'd1; write = 1'b1;
    #1;
    check("stall wr0", 32'(waitrequest), 32'd1);
    tick();
    check("stall wr1", 32'(waitrequest), 32'd1);
    cmd_ready = 1'b1;
    #1;
    check("pop head type", 32'(cmd_type), 32'd1);
    check("pop head motor", 32'(cmd_motor), 32'd0);
    tick();
    cmd_ready = 1'b0;
    #1;
    check("stall released", 32'(waitrequest), 32'd0);
    tick();
    write = 1'b0;
    check("next head type", 32'(cmd_type), 32'd1);
    check("next head motor", 32'(cmd_motor), 32'd1);
    read_expect("fifo level refill", 16'h1000, 32'd8);

    // Drain in order
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d valid", i), 32'(cmd_valid), 32'd1);
      check($sformatf("drain%0d type", i), 32'(cmd_type), (i < 7) ? 32'd1 : 32'd0);
      check($sformatf("drain%0d motor", i), 32'(cmd_motor), (i < 7) ? 32'(i + 1) : 32'd1);
      tick();
    end
    cmd_ready = 1'b0;
    check("drained valid", 32'(cmd_valid), 32'd0);

    // Push and pop in the same cycle
    av_write(16'h0E05, 32'd7, w0);
    address = 16'h0F03; writedata = 32'd1; write = 1'b1; cmd_ready = 1'b1;
    #1;
    check("pp nowait", 32'(waitrequest), 32'd0);
    check("pp head motor", 32'(cmd_motor), 32'd5);
    tick();
    write = 1'b0; cmd_ready = 1'b0;
    check("pp new type", 32'(cmd_type), 32'd1);
    check("pp new motor", 32'(cmd_motor), 32'd3);
    read_expect("pp level", 16'h1000, 32'd1);

    // Status write colliding with a read capture: old value first
    st_wr_valid = 1'b1; st_wr_motor = 8'd3; st_wr_sel = 3'd0; st_wr_data = 32'd1234;
    address = 16'h0403; read = 1'b1;
    tick();
    st_wr_valid = 1'b0;
    check("st_coll old", readdata, 32'd0);
    tick();
    read = 1'b0;
    read_expect("st_coll new", 16'h0403, 32'd1234);
    st_write(8'd3, 3'd4, 32'd77);
    read_expect("cur1 m3", 16'h1203, 32'd77);
    st_write(8'd6, 3'd0, 32'd99);
    read_expect("st bad not counted", 16'h1500, 32'd0);

    // Reset during a read wait cycle with 3 queued commands
    av_write(16'h0E02, 32'd1, w0);
    av_write(16'h0F04, 32'd1, w0);
    read_expect("pre-reset level", 16'h1000, 32'd3);
    address = 16'h0100; read = 1'b1;
    #1;
    check("pre-reset wait", 32'(waitrequest), 32'd1);
    reset = 1'b1;
    #1;
    read = 1'b0;
    #1;
    check("mid-rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid-rst waitrequest", 32'(waitrequest), 32'd0);
    check("mid-rst readdata", readdata, 32'd0);
    check("mid-rst cfg_rd_data", cfg_rd_data, 32'd0);
    check("mid-rst status_hz", status_update_hz, 32'd100);
    tick();
    reset = 1'b0;
    tick();
    read_expect("post-rst setpoint", 16'h0C02, 32'd0);
    read_expect("post-rst ctrl_mode", 16'h0B01, 32'd0);
    read_expect("post-rst kp m2", 16'h0102, 32'd1);
    read_expect("post-rst enc0 m3", 16'h0403, 32'd0);
    read_expect("post-rst level", 16'h1000, 32'd0);
    read_expect("post-rst hz", 16'h1100, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
